// File: rtl/uart_bus_master.sv
// UART byte-command to 32-bit valid/ready bus bridge ('R' read, 'W' write, else '?').
// Optional bus timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module uart_bus_master #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_write_q, is_write_d;
    logic        mem_valid_q, mem_valid_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_ready_q, rx_ready_d;
    logic        rx_fire;
    logic        tx_fire;
    logic        bus_done;
    logic        bus_timeout;

`ifdef BUS_MASTER_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign rx_fire  = rx_valid && rx_ready_q;
    assign tx_fire  = tx_valid_q && tx_ready;
    assign bus_done = mem_valid_q && mem_ready;

`ifdef BUS_MASTER_TIMEOUT_EN
    // Fires on the cycle the stall count would reach the limit, so mem_valid
    // is high for exactly TIMEOUT_CYCLES cycles.
    assign bus_timeout = mem_valid_q && !mem_ready &&
                         (({1'b0, to_cnt_q} + 33'd1) >= {1'b0, TIMEOUT_CYCLES});
`else
    assign bus_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        is_write_d  = is_write_q;
        mem_valid_d = mem_valid_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        rx_ready_d  = rx_ready_q;
`ifdef BUS_MASTER_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                rx_ready_d = 1'b1;
                if (rx_fire) begin
                    cnt_d = '0;
                    if (rx_data == 8'h52 || rx_data == 8'h57) begin
                        is_write_d = (rx_data == 8'h57);
                        state_d    = ADDR;
                    end else begin
                        tx_data_d  = 8'h3F;
                        tx_valid_d = 1'b1;
                        rx_ready_d = 1'b0;
                        state_d    = RESP;
                    end
                end
            end
            ADDR, DATA: begin
                if (rx_fire) begin
                    if (state_q == ADDR) addr_d  = {addr_q[23:0], rx_data};
                    else                 wdata_d = {wdata_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (state_q == ADDR && is_write_q) begin
                            state_d = DATA;
                        end else begin
                            state_d     = BUS;
                            rx_ready_d  = 1'b0;
                            mem_valid_d = 1'b1;
                        end
                    end
                end
            end
            BUS: begin
`ifdef BUS_MASTER_TIMEOUT_EN
                to_cnt_d = (mem_valid_q && !mem_ready) ? to_cnt_q + 32'd1 : to_cnt_q;
`endif
                if (bus_done) begin
                    mem_valid_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    state_d     = RESP;
                    if (is_write_q) begin
                        tx_data_d = 8'h4B;
                        cnt_d     = 2'd0;
                    end else begin
                        tx_data_d = mem_rdata[31:24];
                        rdata_d   = {mem_rdata[23:0], 8'h00};
                        cnt_d     = 2'd3;
                    end
                end else if (bus_timeout) begin
                    mem_valid_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = 8'h54;
                    cnt_d       = 2'd0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // cnt counts response bytes still to send after the current one
                if (tx_fire) begin
                    if (cnt_q == 2'd0) begin
                        tx_valid_d = 1'b0;
                        rx_ready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d     = cnt_q - 2'd1;
                        tx_data_d = rdata_q[31:24];
                        rdata_d   = {rdata_q[23:0], 8'h00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            is_write_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            is_write_q  <= is_write_d;
            mem_valid_q <= mem_valid_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            rx_ready_q  <= rx_ready_d;
`ifdef BUS_MASTER_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = {4{is_write_q}};

endmodule
